// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard scheduler.
//   REG_W     : register-index width of the MIPS register file.
//   REG_ZERO  : $zero index. A load that targets it never creates a hazard.
//   hz_state_e: scheduler states.
//   hz_ctl_t  : bundle of the stall/flush controls that drive the pipeline.
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } hz_ctl_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector.
// The load in EX writes a register that the instruction in ID reads.
//   ID_rs, ID_rt  : source fields of the instruction in ID
//   ID_EX_MemRead : instruction in EX is a load
//   ID_EX_rt      : load destination
//   lu_hit        : ID must wait for the load result
import hazard_ctrl_pkg::*;

module hazard_detect (
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rt,
  output logic             lu_hit
);
  assign lu_hit = ID_EX_MemRead && (ID_EX_rt != REG_ZERO) &&
                  ((ID_EX_rt == ID_rs) || (ID_EX_rt == ID_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Event priority, highest first: dmem freeze, load-use stall,
// branch/jump redirect, fetch wait.
//   clk, reset     : clock and synchronous active-high reset
//   ID_rs/ID_rt    : sources of the instruction in ID
//   ID_EX_MemRead  : EX holds a load
//   ID_EX_rt       : destination of that load
//   redirect       : branch taken or jump resolved in ID
//   imem_ready     : Inst_in is valid this cycle
//   dmem_busy      : data memory stalls the whole pipe
//   PC_Write       : PC load enable
//   IF_ID_Write    : IF_ID load enable
//   IF_Flush       : clear IF_ID
//   ID_EX_Bubble   : zero ID_EX control fields
//   Pipe_Hold      : hold ID_EX, EX_MEM and MEM_WB
//   stall_cnt      : saturating count of cycles with PC_Write=0
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic             redirect,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_EX_Bubble,
  output logic             Pipe_Hold,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);

  hz_state_e  state, state_d, saved, saved_d, eff;
  logic [2:0] lu_cnt, lu_cnt_d;
  logic       discard, discard_d;
  logic       lu_hit;
  hz_ctl_t    ctl;

  hazard_detect u_detect (
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_rt     (ID_EX_rt),
    .lu_hit       (lu_hit)
  );

  // Once memory releases, FREEZE behaves as the state it interrupted.
  // That way the cycle in which dmem_busy falls is already productive.
  assign eff = (state == FREEZE) ? saved : state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      saved   <= RUN;
      lu_cnt  <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_d;
      saved   <= saved_d;
      lu_cnt  <= lu_cnt_d;
      discard <= discard_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = eff;
    saved_d   = saved;
    lu_cnt_d  = lu_cnt;
    discard_d = discard;
    if (dmem_busy) begin
      state_d = FREEZE;
      // Capture the interrupted state only on entry, not on every freeze cycle.
      if (state != FREEZE) saved_d = state;
    end else begin
      case (eff)
        LU_STALL: begin
          lu_cnt_d = lu_cnt - 3'd1;
          if (lu_cnt <= 3'd1) state_d = RUN;
        end
        default: begin
          if (lu_hit) begin
            if (LU_STALL_CYCLES > 1) begin
              state_d  = LU_STALL;
              lu_cnt_d = LU_INIT;
            end
          end else if (redirect) begin
            // An outstanding wrong-path fetch must be squashed on arrival.
            // A pending discard survives, because the target fetch is not yet issued.
            discard_d = discard | ~imem_ready;
          end else if (imem_ready && discard) begin
            discard_d = 1'b0;
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    ctl = '0;
    if (reset) begin
      ctl.if_flush     = 1'b1;
      ctl.id_ex_bubble = 1'b1;
    end else if (dmem_busy) begin
      ctl.pipe_hold = 1'b1;
    end else if (eff == LU_STALL || lu_hit) begin
      ctl.id_ex_bubble = 1'b1;
    end else if (redirect) begin
      ctl.pc_write = 1'b1;
      ctl.if_flush = 1'b1;
    end else if (imem_ready) begin
      ctl.pc_write    = 1'b1;
      ctl.if_flush    = discard;
      ctl.if_id_write = ~discard;
    end
  end

  assign PC_Write     = ctl.pc_write;
  assign IF_ID_Write  = ctl.if_id_write;
  assign IF_Flush     = ctl.if_flush;
  assign ID_EX_Bubble = ctl.id_ex_bubble;
  assign Pipe_Hold    = ctl.pipe_hold;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!ctl.pc_write && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
